instr_cache_ctrl: RTL and testbench

Direct-mapped instruction-cache controller that drives the 16-entry, 23-bit tag SRAM and its companion 256-bit data SRAM, and answers fetch requests from the front end. Sits between the fetch unit (ufp side) and the memory arbiter (dfp side). It owns the SRAM control pins, holds per-set valid bits in flops because the SRAMs have no reset, and sequences miss refills.

---
 rtl/icache_pkg.sv | 40 ++++
 rtl/instr_cache_ctrl_if.sv | 63 ++++++
 rtl/instr_cache_valid_array.sv | 36 +++
 rtl/instr_cache_ctrl.sv | 166 ++++++++++++++++
 tb/tb_instr_cache_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared constants, FSM state type and address-slice helpers for
//            the direct-mapped instruction cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int SET_BITS    = 4;
    localparam int TAG_BITS    = 23;
    localparam int LINE_BITS   = 256;
    localparam int NUM_SETS    = 1 << SET_BITS;
    localparam int OFFSET_BITS = 5;
    localparam int WORD_BITS   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_FETCH   = 2'd2,
        ST_FILL    = 2'd3
    } state_t;

    // Tag field: address bits [31:9]
    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [31:0] addr);
        return TAG_BITS'(addr >> (OFFSET_BITS + SET_BITS));
    endfunction

    // Set index: address bits [8:5]
    function automatic logic [SET_BITS-1:0] addr_set(input logic [31:0] addr);
        return SET_BITS'(addr >> OFFSET_BITS);
    endfunction

    // 32-bit word within the line: address bits [4:2]
    function automatic logic [WORD_BITS-1:0] addr_word(input logic [31:0] addr);
        return WORD_BITS'(addr >> 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_cache_ctrl_if
// Purpose  : Bundles the fetch-side, refill-side and SRAM pins of the
//            instruction cache controller. The master modport is the
//            controller; the slave modport is its surroundings.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_cache_ctrl_if;
    import icache_pkg::*;

    // Fetch unit side
    logic [31:0]           ufp_addr;
    logic [3:0]            ufp_rmask;
    logic                  ufp_ready;
    logic [31:0]           ufp_rdata;
    logic                  ufp_resp;
    logic                  flush;

    // Memory arbiter side
    logic [31:0]           dfp_addr;
    logic                  dfp_read;
    logic [LINE_BITS-1:0]  dfp_rdata;
    logic                  dfp_resp;

    // Tag SRAM
    logic                  tag_csb0;
    logic                  tag_web0;
    logic [SET_BITS-1:0]   tag_addr0;
    logic [TAG_BITS-1:0]   tag_din0;
    logic [TAG_BITS-1:0]   tag_dout0;

    // Data SRAM
    logic                  data_csb0;
    logic                  data_web0;
    logic [SET_BITS-1:0]   data_addr0;
    logic [LINE_BITS-1:0]  data_din0;
    logic [LINE_BITS-1:0]  data_dout0;

    modport master (
        input  ufp_addr, ufp_rmask, flush,
        output ufp_ready, ufp_rdata, ufp_resp,
        output dfp_addr, dfp_read,
        input  dfp_rdata, dfp_resp,
        output tag_csb0, tag_web0, tag_addr0, tag_din0,
        input  tag_dout0,
        output data_csb0, data_web0, data_addr0, data_din0,
        input  data_dout0
    );

    modport slave (
        output ufp_addr, ufp_rmask, flush,
        input  ufp_ready, ufp_rdata, ufp_resp,
        input  dfp_addr, dfp_read,
        output dfp_rdata, dfp_resp,
        input  tag_csb0, tag_web0, tag_addr0, tag_din0,
        output tag_dout0,
        input  data_csb0, data_web0, data_addr0, data_din0,
        output data_dout0
    );

endinterface
`default_nettype wire

// File: rtl/instr_cache_valid_array.sv
`default_nettype none
// ============================================================================
// Module   : instr_cache_valid_array
// Purpose  : Per-set valid bits held in flops, since the tag/data SRAMs power
//            up with arbitrary contents. Supports single-set mark-valid and
//            whole-array flush, with flush taking priority.
// Revision : 1.0 - initial release
// ============================================================================
module instr_cache_valid_array
    import icache_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                set_en,
    input  wire logic [SET_BITS-1:0] set_idx,
    input  wire logic                flush,
    output logic [NUM_SETS-1:0]      valid
);

    logic [NUM_SETS-1:0] r_valid;

    // Flush outranks a same-cycle fill so a fence.i racing a refill leaves the line invalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (set_en) begin
            r_valid[set_idx] <= 1'b1;
        end
    end

    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_cache_ctrl
// Purpose  : Direct-mapped instruction cache controller. Drives the tag and
//            data SRAM control pins, answers fetch requests with one-cycle
//            hit latency and sequences line refills from the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_cache_ctrl
    import icache_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    instr_cache_ctrl_if.master bus
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [31:0]            r_addr;
    logic [NUM_SETS-1:0]    w_valid;

    logic                   w_req;
    logic                   w_hit;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_fill;
    logic                   w_csb;
    logic                   w_web;
    logic [SET_BITS-1:0]    w_sram_addr;
    logic [TAG_BITS-1:0]    w_tag;
    logic [SET_BITS-1:0]    w_set;
    logic [WORD_BITS-1:0]   w_word;

    assign w_req    = |bus.ufp_rmask;
    assign w_tag    = addr_tag(r_addr);
    assign w_set    = addr_set(r_addr);
    assign w_word   = addr_word(r_addr);
    // The valid flop is read before any same-cycle flush lands, so a hit in the
    // flush cycle still reflects the pre-flush contents.
    assign w_hit    = w_valid[w_set] && (bus.tag_dout0 == w_tag);
    assign w_accept = w_ready && w_req;

    instr_cache_valid_array u_valid (
        .clk     (clk),
        .rst     (rst),
        .set_en  (w_fill),
        .set_idx (w_set),
        .flush   (bus.flush),
        .valid   (w_valid)
    );

    // Capture the fetch address whenever a request is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= bus.ufp_addr;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!w_hit) begin
                    w_next_state = ST_FETCH;
                end else if (!w_req) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.dfp_resp) begin
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                w_next_state = ST_COMPARE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Per-state outputs: handshake, refill request and SRAM control
    always_comb begin
        w_ready       = 1'b0;
        bus.ufp_resp  = 1'b0;
        bus.ufp_rdata = '0;
        bus.dfp_read  = 1'b0;
        bus.dfp_addr  = '0;
        w_csb         = 1'b1;
        w_web         = 1'b1;
        w_sram_addr   = w_set;
        w_fill        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (w_req) begin
                    w_csb       = 1'b0;
                    w_sram_addr = addr_set(bus.ufp_addr);
                end
            end
            ST_COMPARE: begin
                if (w_hit) begin
                    w_ready       = 1'b1;
                    bus.ufp_resp  = 1'b1;
                    bus.ufp_rdata = bus.data_dout0[{w_word, 5'b0} +: 32];
                    if (w_req) begin
                        w_csb       = 1'b0;
                        w_sram_addr = addr_set(bus.ufp_addr);
                    end
                end else begin
                    bus.dfp_read = 1'b1;
                    bus.dfp_addr = {w_tag, w_set, 5'b0};
                end
            end
            ST_FETCH: begin
                bus.dfp_read = 1'b1;
                bus.dfp_addr = {w_tag, w_set, 5'b0};
                if (bus.dfp_resp) begin
                    w_csb  = 1'b0;
                    w_web  = 1'b0;
                    w_fill = 1'b1;
                end
            end
            ST_FILL: begin
                // Re-read the freshly written set; this read also clears the
                // SRAM's latched write enable before any later write.
                w_csb = 1'b0;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    assign bus.ufp_ready  = w_ready;

    assign bus.tag_csb0   = w_csb;
    assign bus.tag_web0   = w_web;
    assign bus.tag_addr0  = w_sram_addr;
    assign bus.tag_din0   = w_tag;

    assign bus.data_csb0  = w_csb;
    assign bus.data_web0  = w_web;
    assign bus.data_addr0 = w_sram_addr;
    assign bus.data_din0  = bus.dfp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_instr_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_cache_ctrl
// Purpose  : Self-checking bench for instr_cache_ctrl with SRAM models, a
//            line-memory responder and a set/tag reference cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_cache_ctrl;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_cache_ctrl_if bus();

    instr_cache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- SRAM models ----------------
    logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS];
    logic [LINE_BITS-1:0] data_mem [NUM_SETS];
    logic [SET_BITS-1:0]  tag_la   = '0;
    logic [SET_BITS-1:0]  data_la  = '0;
    logic                 tag_wp   = 1'b0;
    logic                 data_wp  = 1'b0;
    logic [SET_BITS-1:0]  tag_wa   = '0;
    logic [SET_BITS-1:0]  data_wa  = '0;
    logic [TAG_BITS-1:0]  tag_wd   = '0;
    logic [LINE_BITS-1:0] data_wd  = '0;

    // Tag SRAM: control latched at the edge, write lands one edge later
    always @(posedge clk) begin
        if (tag_wp) tag_mem[tag_wa] <= tag_wd;
        tag_wp <= 1'b0;
        if (!bus.tag_csb0) begin
            tag_la <= bus.tag_addr0;
            tag_wp <= !bus.tag_web0;
            tag_wa <= bus.tag_addr0;
            tag_wd <= bus.tag_din0;
        end
    end

    // Data SRAM: same timing as the tag array
    always @(posedge clk) begin
        if (data_wp) data_mem[data_wa] <= data_wd;
        data_wp <= 1'b0;
        if (!bus.data_csb0) begin
            data_la <= bus.data_addr0;
            data_wp <= !bus.data_web0;
            data_wa <= bus.data_addr0;
            data_wd <= bus.data_din0;
        end
    end

    assign bus.tag_dout0  = tag_mem[tag_la];
    assign bus.data_dout0 = data_mem[data_la];

    // ---------------- reference model ----------------
    bit          ref_valid [NUM_SETS];
    logic [31:0] ref_tag   [NUM_SETS];
    int          checks    = 0;
    int          errors    = 0;
    int          resp_cnt  = 0;
    int          exp_resp  = 0;

    function automatic int set_of(input logic [31:0] a);
        return int'((a / 32) % 16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / 512;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return ref_valid[set_of(a)] && (ref_tag[set_of(a)] == tag_of(a));
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < NUM_SETS; i++) ref_valid[i] = 1'b0;
    endfunction

    // Backing memory contents: line 0x1000 holds 0xA0..0xA7, others are address-derived
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] line = a & 32'hFFFF_FFE0;
        logic [31:0] w    = (a % 32) / 4;
        if (line == 32'h0000_1000) return 32'h0000_00A0 + w;
        return (a & 32'hFFFF_FFFC) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [LINE_BITS-1:0] line_of(input logic [31:0] la);
        logic [LINE_BITS-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = mem_word(la + 32'(i * 4));
        return l;
    endfunction

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Count response pulses, sampled mid-cycle
    always @(negedge clk) begin
        #2;
        if (bus.ufp_resp === 1'b1) resp_cnt <= resp_cnt + 1;
    end

    // ---------------- scenario tasks ----------------
    // Serve one refill starting from the COMPARE-miss cycle; returns at the next COMPARE
    task automatic refill(input logic [31:0] la, input bit fl, input string nm);
        int lat = $urandom_range(0, 3);
        int s   = set_of(la);
        logic [LINE_BITS-1:0] line = line_of(la);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            bus.ufp_rmask = 4'($urandom_range(0, 15));
            bus.ufp_addr  = $urandom;
            #1;
            checks++;
            if (bus.dfp_read !== 1'b1 || bus.dfp_addr !== la || bus.ufp_ready !== 1'b0 || bus.tag_csb0 !== 1'b1) begin
                errors++;
                $display("FAIL %s fetch_hold: got read=%b addr=%h ready=%b csb=%b, expected 1 %h 0 1",
                         nm, bus.dfp_read, bus.dfp_addr, bus.ufp_ready, bus.tag_csb0, la);
            end
        end
        @(negedge clk);
        bus.ufp_rmask = 4'h0;
        bus.dfp_resp  = 1'b1;
        bus.dfp_rdata = line;
        bus.flush     = fl;
        #1;
        checks++;
        if ({bus.tag_csb0, bus.tag_web0, bus.data_csb0, bus.data_web0} !== 4'b0000) begin
            errors++;
            $display("FAIL %s fill_write_ctl: got %b expected 0000", nm,
                     {bus.tag_csb0, bus.tag_web0, bus.data_csb0, bus.data_web0});
        end
        checks++;
        if (bus.tag_din0 !== TAG_BITS'(tag_of(la)) || bus.tag_addr0 !== 4'(s) ||
            bus.data_addr0 !== 4'(s) || bus.data_din0 !== line) begin
            errors++;
            $display("FAIL %s fill_write_data: got tag=%h set=%h/%h expected tag=%h set=%h",
                     nm, bus.tag_din0, bus.tag_addr0, bus.data_addr0, TAG_BITS'(tag_of(la)), 4'(s));
        end
        @(negedge clk);
        bus.dfp_resp  = 1'b0;
        bus.flush     = 1'b0;
        bus.dfp_rdata = rand_line();
        ref_valid[s]  = 1'b1;
        ref_tag[s]    = tag_of(la);
        if (fl) model_flush();
        #1;
        checks++;
        if (bus.dfp_read !== 1'b0 || bus.ufp_resp !== 1'b0 || bus.ufp_ready !== 1'b0 ||
            {bus.tag_csb0, bus.tag_web0, bus.data_csb0, bus.data_web0} !== 4'b0101) begin
            errors++;
            $display("FAIL %s fill_read: got read=%b resp=%b ready=%b ctl=%b expected 0 0 0 0101",
                     nm, bus.dfp_read, bus.ufp_resp, bus.ufp_ready,
                     {bus.tag_csb0, bus.tag_web0, bus.data_csb0, bus.data_web0});
        end
        @(negedge clk);
        #1;
    endtask

    // One complete fetch from IDLE, checked against the reference model
    task automatic access(input logic [31:0] a, input bit flush_at_resp, input string nm);
        bit          exp_hit;
        logic [31:0] la = a & 32'hFFFF_FFE0;
        int          rounds = 0;
        exp_hit = model_hit(a);
        exp_resp++;
        @(negedge clk);
        bus.ufp_addr  = a;
        bus.ufp_rmask = 4'($urandom_range(1, 15));
        #1;
        checks++;
        if (bus.ufp_ready !== 1'b1 || bus.ufp_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_handshake: got ready=%b resp=%b expected 1 0", nm, bus.ufp_ready, bus.ufp_resp);
        end
        checks++;
        if ({bus.tag_csb0, bus.tag_web0, bus.data_csb0, bus.data_web0} !== 4'b0101 ||
            bus.tag_addr0 !== 4'(set_of(a)) || bus.data_addr0 !== 4'(set_of(a))) begin
            errors++;
            $display("FAIL %s lookup_read: got ctl=%b addr=%h expected 0101 %h", nm,
                     {bus.tag_csb0, bus.tag_web0, bus.data_csb0, bus.data_web0}, bus.tag_addr0, 4'(set_of(a)));
        end
        @(negedge clk);
        bus.ufp_rmask = 4'h0;
        bus.ufp_addr  = $urandom;
        #1;
        while (!exp_hit && rounds < 3) begin
            checks++;
            if (bus.dfp_read !== 1'b1 || bus.dfp_addr !== la) begin
                errors++;
                $display("FAIL %s miss_request: got read=%b addr=%h expected 1 %h", nm, bus.dfp_read, bus.dfp_addr, la);
            end
            checks++;
            if (bus.ufp_resp !== 1'b0 || bus.ufp_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s miss_handshake: got resp=%b ready=%b expected 0 0", nm, bus.ufp_resp, bus.ufp_ready);
            end
            refill(la, flush_at_resp && rounds == 0, nm);
            exp_hit = model_hit(a);
            rounds++;
        end
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.dfp_read !== 1'b0) begin
            errors++;
            $display("FAIL %s hit_resp: got resp=%b read=%b expected 1 0", nm, bus.ufp_resp, bus.dfp_read);
        end
        checks++;
        if (bus.ufp_rdata !== mem_word(a)) begin
            errors++;
            $display("FAIL %s hit_rdata: got %h expected %h", nm, bus.ufp_rdata, mem_word(a));
        end
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_flush();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.ufp_resp !== 1'b0 || bus.ufp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_ufp: got resp=%b rdata=%h expected 0 0", bus.ufp_resp, bus.ufp_rdata);
        end
        checks++;
        if (bus.dfp_read !== 1'b0 || bus.dfp_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_dfp: got read=%b addr=%h expected 0 0", bus.dfp_read, bus.dfp_addr);
        end
        checks++;
        if ({bus.tag_csb0, bus.tag_web0, bus.data_csb0, bus.data_web0} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_sram: got %b expected 1111", {bus.tag_csb0, bus.tag_web0, bus.data_csb0, bus.data_web0});
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.ufp_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", bus.ufp_ready);
        end
    endtask

    task automatic test_cold_miss();
        access(32'h0000_1004, 1'b0, "cold_miss");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.ufp_addr  = 32'h0000_1004;
        bus.ufp_rmask = 4'hF;
        #1;
        checks++;
        if (bus.ufp_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready0: got %b expected 1", bus.ufp_ready);
        end
        @(negedge clk);
        bus.ufp_addr  = 32'h0000_1008;
        bus.ufp_rmask = 4'h1;
        #1;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_00A1 || bus.ufp_ready !== 1'b1 || bus.dfp_read !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got resp=%b rdata=%h ready=%b read=%b expected 1 000000a1 1 0",
                     bus.ufp_resp, bus.ufp_rdata, bus.ufp_ready, bus.dfp_read);
        end
        checks++;
        if (bus.tag_csb0 !== 1'b0 || bus.tag_addr0 !== 4'h0) begin
            errors++;
            $display("FAIL b2b_reissue: got csb=%b addr=%h expected 0 0", bus.tag_csb0, bus.tag_addr0);
        end
        @(negedge clk);
        bus.ufp_rmask = 4'h0;
        #1;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_00A2 || bus.dfp_read !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got resp=%b rdata=%h read=%b expected 1 000000a2 0",
                     bus.ufp_resp, bus.ufp_rdata, bus.dfp_read);
        end
        exp_resp += 2;
    endtask

    task automatic test_conflict();
        access(32'h0000_1204, 1'b0, "conflict_new");
        access(32'h0000_1004, 1'b0, "conflict_back");
    endtask

    task automatic test_flush();
        access(32'h0000_1004, 1'b0, "flush_warm");
        // Flush raised in a hit cycle still returns the pre-flush hit
        @(negedge clk);
        bus.ufp_addr  = 32'h0000_1010;
        bus.ufp_rmask = 4'hF;
        @(negedge clk);
        bus.ufp_rmask = 4'h0;
        bus.flush     = 1'b1;
        #1;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_00A4) begin
            errors++;
            $display("FAIL flush_in_compare: got resp=%b rdata=%h expected 1 000000a4", bus.ufp_resp, bus.ufp_rdata);
        end
        exp_resp++;
        @(negedge clk);
        bus.flush = 1'b0;
        model_flush();
        access(32'h0000_1004, 1'b0, "after_flush");
        flush_pulse();
        access(32'h0000_1004, 1'b1, "flush_with_resp");
    endtask

    task automatic test_reset_mid_fetch();
        access(32'h0000_1004, 1'b0, "pre_reset_warm");
        @(negedge clk);
        bus.ufp_addr  = 32'h0000_2024;
        bus.ufp_rmask = 4'hF;
        @(negedge clk);
        bus.ufp_rmask = 4'h0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.dfp_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_fetch_pre: got read=%b expected 1", bus.dfp_read);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.dfp_read !== 1'b0 || bus.ufp_resp !== 1'b0 || bus.dfp_addr !== 32'h0 || bus.tag_csb0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: got read=%b resp=%b addr=%h csb=%b expected 0 0 0 1",
                     bus.dfp_read, bus.ufp_resp, bus.dfp_addr, bus.tag_csb0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_flush();
        access(32'h0000_1004, 1'b0, "post_reset_old");
        access(32'h0000_2024, 1'b0, "post_reset_new");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            a = (32'($urandom_range(1, 4)) << 9) | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) flush_pulse();
            access(a, $urandom_range(0, 7) == 0, "random");
        end
    endtask

    task automatic test_resp_count();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (resp_cnt !== exp_resp) begin
            errors++;
            $display("FAIL resp_count: got %0d expected %0d", resp_cnt, exp_resp);
        end
    endtask

    initial begin
        bus.ufp_addr  = 32'h0;
        bus.ufp_rmask = 4'h0;
        bus.flush     = 1'b0;
        bus.dfp_resp  = 1'b0;
        bus.dfp_rdata = '0;
        model_flush();
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush();
        test_reset_mid_fetch();
        test_random();
        test_resp_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
